condicionador_botoes: RTL and testbench

Upstream input stage for the stack-calculator top level. It takes the raw active-low KEY[1:0] pins, synchronises and debounces each one, and classifies each press as a single-key action or a two-key chord.
- A single-key action produces a one-cycle pulse (pulso_key0 / pulso_key1) to the control unit.
- A chord produces a level reset request (reset_keys) to the global reset OR.
- It runs on the divided system clock and replaces the ad-hoc NOT/AND/edge-detect gating in the top level.

---
 rtl/condicionador_botoes_if.sv | 27 ++
 rtl/condicionador_botoes.sv | 180 ++++++++++++++++++
 tb/tb_condicionador_botoes.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/condicionador_botoes_if.sv
// Button conditioner bus: the raw active-low KEY pins going in and the
// conditioned pulses, chord reset request and debounced key levels coming out.
interface condicionador_botoes_if;
    logic [1:0] KEY;
    logic       pulso_key0;
    logic       pulso_key1;
    logic       reset_keys;
    logic [1:0] key_estavel;

    // Environment side: drives the pins, observes the conditioned outputs
    modport master (
        output KEY,
        input  pulso_key0,
        input  pulso_key1,
        input  reset_keys,
        input  key_estavel
    );

    // Conditioner side
    modport slave (
        input  KEY,
        output pulso_key0,
        output pulso_key1,
        output reset_keys,
        output key_estavel
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Input stage for the stack calculator: synchronises and debounces the two
// active-low pushbuttons, then classifies each press as a single-key action
// (one-cycle pulse) or a two-key chord (level reset request). Reset is
// power-on only; reset_keys must never feed back into it.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CHORD_WINDOW    = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    condicionador_botoes_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WIN_W = (CHORD_WINDOW < 2) ? 1 : $clog2(CHORD_WINDOW + 1);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        ESPERA = 3'd1,
        ACAO   = 3'd2,
        CHORD  = 3'd3,
        LIBERA = 3'd4
    } estado_t;

    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [CNT_W-1:0] deb_cnt_r [2];
    logic [1:0]       estavel_r;

    estado_t          state_r;
    estado_t          state_s;
    logic             sel_r;      // latched key id of the pending single press
    logic             sel_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_cnt_s;
    logic             pulse0_s;
    logic             pulse1_s;
    logic             held_s;     // latched key still pressed
    logic             other_s;    // the non-latched key is pressed

    logic             pulso_key0_r;
    logic             pulso_key1_r;
    logic             reset_keys_r;

    assign held_s  = sel_r ? estavel_r[1] : estavel_r[0];
    assign other_s = sel_r ? estavel_r[0] : estavel_r[1];

    // Two-stage synchroniser on the inverted pins (1 = pressed after this point)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= ~bus.KEY;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debounce: the stable level flips only after an unbroken run of mismatches
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estavel_r <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                deb_cnt_r[n] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (sync2_r[n] != estavel_r[n]) begin
                    if (deb_cnt_r[n] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        estavel_r[n] <= ~estavel_r[n];
                        deb_cnt_r[n] <= {CNT_W{1'b0}};
                    end else begin
                        deb_cnt_r[n] <= deb_cnt_r[n] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_r[n] <= {CNT_W{1'b0}};
                end
            end
        end
    end

    // Classifier next-state: single press waits a short window for a chord partner
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        win_cnt_s = win_cnt_r;
        pulse0_s  = 1'b0;
        pulse1_s  = 1'b0;
        case (state_r)
            OCIOSO: begin
                if (estavel_r == 2'b11) begin
                    state_s = CHORD;
                end else if (estavel_r == 2'b01) begin
                    state_s   = ESPERA;
                    sel_s     = 1'b0;
                    win_cnt_s = WIN_W'(CHORD_WINDOW);
                end else if (estavel_r == 2'b10) begin
                    state_s   = ESPERA;
                    sel_s     = 1'b1;
                    win_cnt_s = WIN_W'(CHORD_WINDOW);
                end else begin
                    state_s = OCIOSO;
                end
            end
            ESPERA: begin
                win_cnt_s = win_cnt_r - WIN_W'(1);
                if (estavel_r == 2'b11) begin
                    // Partner joined in time: chord, the single press is dropped
                    state_s   = CHORD;
                    win_cnt_s = {WIN_W{1'b0}};
                end else if (!held_s) begin
                    // Tap shorter than the window still counts as an action
                    state_s   = OCIOSO;
                    win_cnt_s = {WIN_W{1'b0}};
                    pulse0_s  = ~sel_r;
                    pulse1_s  = sel_r;
                end else if (win_cnt_r == WIN_W'(1)) begin
                    state_s  = ACAO;
                    pulse0_s = ~sel_r;
                    pulse1_s = sel_r;
                end else begin
                    state_s = ESPERA;
                end
            end
            ACAO: begin
                if (other_s) begin
                    // Late second key: swallow it until everything is released
                    state_s = LIBERA;
                end else if (estavel_r == 2'b00) begin
                    state_s = OCIOSO;
                end else begin
                    state_s = ACAO;
                end
            end
            CHORD: begin
                if (estavel_r != 2'b11) begin
                    state_s = LIBERA;
                end else begin
                    state_s = CHORD;
                end
            end
            LIBERA: begin
                if (estavel_r == 2'b00) begin
                    state_s = OCIOSO;
                end else begin
                    state_s = LIBERA;
                end
            end
            default: begin
                state_s   = OCIOSO;
                win_cnt_s = {WIN_W{1'b0}};
            end
        endcase
    end

    // Classifier state register and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= OCIOSO;
            sel_r        <= 1'b0;
            win_cnt_r    <= {WIN_W{1'b0}};
            pulso_key0_r <= 1'b0;
            pulso_key1_r <= 1'b0;
            reset_keys_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            win_cnt_r    <= win_cnt_s;
            pulso_key0_r <= pulse0_s;
            pulso_key1_r <= pulse1_s;
            reset_keys_r <= (state_s == CHORD);
        end
    end

    assign bus.pulso_key0  = pulso_key0_r;
    assign bus.pulso_key1  = pulso_key1_r;
    assign bus.reset_keys  = reset_keys_r;
    assign bus.key_estavel = estavel_r;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: a table of key-press scenarios with the
// expected cycle of every pulse, chord level and debounced level, plus a
// hand-written reset-while-waiting sequence. Expected output words are queued
// when each cycle is driven and compared after the following clock edge.
module tb_condicionador_botoes;

    logic clk;
    logic rst;

    condicionador_botoes_if bus_a ();
    condicionador_botoes_if bus_b ();

    condicionador_botoes #(.DEBOUNCE_CYCLES(4), .CHORD_WINDOW(3)) dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_a.slave)
    );

    condicionador_botoes #(.DEBOUNCE_CYCLES(4), .CHORD_WINDOW(8)) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One scenario. Cycle k = outputs after the k-th edge following drive 0.
    // Ranges are [on, off); a pulse field of -1 means no pulse expected.
    typedef struct {
        string       name;
        logic [63:0] k0;
        logic [63:0] k1;
        bit          wide;
        int          p0;
        int          p1;
        int          rk_on;
        int          rk_off;
        int          s0_on;
        int          s0_off;
        int          s1_on;
        int          s1_off;
        int          s1b_on;
        int          s1b_off;
    } vec_t;

    typedef struct {
        logic [4:0] v;
        bit         wide;
        string      name;
        int         k;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    vec_t vecs[11];

    function automatic logic [63:0] span(input int a, input int b);
        logic [63:0] m;
        m = 64'd0;
        for (int i = a; i < b; i++) m[i] = 1'b1;
        return m;
    endfunction

    // {pulso_key0, pulso_key1, reset_keys, key_estavel[1], key_estavel[0]}
    function automatic logic [4:0] obs(input bit wide);
        if (wide)
            return {bus_b.pulso_key0, bus_b.pulso_key1, bus_b.reset_keys, bus_b.key_estavel};
        else
            return {bus_a.pulso_key0, bus_a.pulso_key1, bus_a.reset_keys, bus_a.key_estavel};
    endfunction

    task automatic step(input logic [1:0] pressed, input logic r, input logic [4:0] e,
                        input bit wide, input string nm, input int k);
        exp_t       x;
        logic [4:0] got;
        bus_a.KEY = ~pressed;
        bus_b.KEY = ~pressed;
        rst       = r;
        x.v = e; x.wide = wide; x.name = nm; x.k = k;
        q.push_back(x);
        @(posedge clk);
        #1;
        x   = q.pop_front();
        got = obs(x.wide);
        checks++;
        if (got !== x.v) begin
            failures++;
            $display("FAIL %s cycle %0d: got {p0,p1,rk,est1,est0}=%b required %b",
                     x.name, x.k, got, x.v);
        end
    endtask

    task automatic reset_dut(input bit wide, input string nm);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 5'b00000, wide, nm, i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [63:0] bmask;
        vec_t        v;
        logic [4:0]  e;
        int          k;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_a.KEY = 2'b11;
        bus_b.KEY = 2'b11;

        bmask = span(6, 26);
        bmask[0] = 1'b1;
        bmask[2] = 1'b1;
        bmask[4] = 1'b1;

        //          name               k0                     k1                            w  p0  p1  rk      s0      s1      s1b
        vecs[0]  = '{"single_k0",      span(0,20),            64'd0,                        0, 10, -1, 0,0,    6,26,   0,0,    0,0};
        vecs[1]  = '{"bounce_k1",      64'd0,                 bmask,                        0, -1, 16, 0,0,    0,0,    12,32,  0,0};
        vecs[2]  = '{"chord_late1",    span(0,16),            span(1,16),                   0, -1, -1, 8,23,   6,22,   7,22,   0,0};
        vecs[3]  = '{"late_second",    span(0,24),            span(8,24) | span(30,45),     0, 10, 40, 0,0,    6,30,   14,30,  36,51};
        vecs[4]  = '{"tap_w8",         span(0,5),             64'd0,                        1, 12, -1, 0,0,    6,11,   0,0,    0,0};
        vecs[5]  = '{"short_w3",       span(0,5),             64'd0,                        0, 10, -1, 0,0,    6,11,   0,0,    0,0};
        vecs[6]  = '{"bounce3",        span(0,3),             64'd0,                        0, -1, -1, 0,0,    0,0,    0,0,    0,0};
        vecs[7]  = '{"min_press4",     span(0,4),             64'd0,                        0, 10, -1, 0,0,    6,10,   0,0,    0,0};
        vecs[8]  = '{"chord_now",      span(0,12),            span(0,12),                   0, -1, -1, 7,19,   6,18,   6,18,   0,0};
        vecs[9]  = '{"chord_window",   span(3,20),            span(0,20),                   0, -1, -1, 10,27,  9,26,   6,26,   0,0};
        vecs[10] = '{"late_by_4",      span(4,20),            span(0,20),                   0, -1, 10, 0,0,    10,26,  6,26,   0,0};

        @(posedge clk);
        #1;

        for (int n = 0; n < 11; n++) begin
            v = vecs[n];
            reset_dut(v.wide, {v.name, "_reset"});
            for (int c = 0; c < 60; c++) begin
                k = c + 1;
                e[4] = (k == v.p0);
                e[3] = (k == v.p1);
                e[2] = (k >= v.rk_on) && (k < v.rk_off);
                e[1] = ((k >= v.s1_on) && (k < v.s1_off)) || ((k >= v.s1b_on) && (k < v.s1b_off));
                e[0] = (k >= v.s0_on) && (k < v.s0_off);
                step({v.k1[c], v.k0[c]}, 1'b0, e, v.wide, v.name, k);
            end
        end

        // KEY0 held; a one-cycle Reset while the press waits in its window drops
        // the pending pulse, and the still-held key is taken as a fresh press.
        reset_dut(1'b0, "rst_mid_reset");
        for (int c = 0; c < 30; c++) begin
            k = c + 1;
            e[4] = (k == 18);
            e[3] = 1'b0;
            e[2] = 1'b0;
            e[1] = 1'b0;
            e[0] = ((k >= 6) && (k < 8)) || (k >= 14);
            step(2'b01, (c == 7), e, 1'b0, "rst_mid", k);
        end

        // Release and let it settle back to idle
        for (int c = 0; c < 8; c++) begin
            k = c + 1;
            e = {4'b0000, (k < 6)};
            step(2'b00, 1'b0, e, 1'b0, "rst_mid_release", k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
